// File: rtl/sram_arb_pkg.sv
// Shared types and default sizes for the audio SRAM arbiter.
package sram_arb_pkg;

  localparam int unsigned ADDR_W_DEF  = 20;
  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned ACC_CYC_DEF = 2;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_SETUP = 3'd1,
    ST_WR_PULSE = 3'd2,
    ST_WR_HOLD  = 3'd3,
    ST_RD_PULSE = 3'd4,
    ST_RD_DONE  = 3'd5
  } sram_arb_state_e;

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } sram_arb_grant_e;

endpackage

// File: rtl/sram_arbiter.sv
// Round-robin arbiter and fixed-timing access sequencer for the shared audio SRAM.
// Every output is a register loaded from the next-state decode.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ACC_CYC = ACC_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic              sram_ce_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACC_CYC - 1);

  sram_arb_state_e  state_q, state_d;
  sram_arb_grant_e  last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dq_q, dq_d;
  logic [DATA_W-1:0] cap_q, cap_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic we_n_q, we_n_d, oe_n_q, oe_n_d, ce_n_q, ce_n_d;
  logic dq_oe_q, dq_oe_d, wr_ack_q, wr_ack_d, rd_ack_q, rd_ack_d, busy_q, busy_d;

  // Next-state, grant and registered-output decode
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    dq_d      = dq_q;
    cap_d     = cap_q;
    rd_data_d = rd_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (wr_req && (!rd_req || last_q == GRANT_RD)) begin
          state_d = ST_WR_SETUP;
          last_d  = GRANT_WR;
          addr_d  = wr_addr;
          dq_d    = wr_data;
        end else if (rd_req) begin
          state_d = ST_RD_PULSE;
          last_d  = GRANT_RD;
          addr_d  = rd_addr;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_WR_SETUP: begin
        state_d = ST_WR_PULSE;
        cnt_d   = CNT_LOAD;
      end
      ST_WR_PULSE: begin
        if (cnt_q == '0) state_d = ST_WR_HOLD;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_WR_HOLD: state_d = ST_IDLE;
      ST_RD_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_RD_DONE;
          cnt_d   = CNT_W'(1);
          cap_d   = sram_dq_i;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      // Capture cycle then ack cycle, so reads match the write latency
      ST_RD_DONE: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    we_n_d   = (state_d != ST_WR_PULSE);
    oe_n_d   = (state_d != ST_RD_PULSE);
    ce_n_d   = (state_d == ST_IDLE);
    dq_oe_d  = (state_d == ST_WR_SETUP) || (state_d == ST_WR_PULSE) ||
               (state_d == ST_WR_HOLD);
    wr_ack_d = (state_d == ST_WR_HOLD);
    rd_ack_d = (state_d == ST_RD_DONE) && (cnt_d == '0);
    busy_d   = (state_d != ST_IDLE);
    if (rd_ack_d) rd_data_d = cap_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      last_q    <= GRANT_RD;
      cnt_q     <= '0;
      addr_q    <= '0;
      dq_q      <= '0;
      cap_q     <= '0;
      rd_data_q <= '0;
      we_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      ce_n_q    <= 1'b1;
      dq_oe_q   <= 1'b0;
      wr_ack_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      dq_q      <= dq_d;
      cap_q     <= cap_d;
      rd_data_q <= rd_data_d;
      we_n_q    <= we_n_d;
      oe_n_q    <= oe_n_d;
      ce_n_q    <= ce_n_d;
      dq_oe_q   <= dq_oe_d;
      wr_ack_q  <= wr_ack_d;
      rd_ack_q  <= rd_ack_d;
      busy_q    <= busy_d;
    end
  end

  assign sram_addr  = addr_q;
  assign sram_dq_o  = dq_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_we_n  = we_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_ub_n  = ce_n_q;
  assign sram_lb_n  = ce_n_q;
  assign wr_ack     = wr_ack_q;
  assign rd_ack     = rd_ack_q;
  assign rd_data    = rd_data_q;
  assign busy       = busy_q;

endmodule
